// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit for the EX stage. Accepts
//                MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a fixed-latency
//                operation and owns the architectural HI/LO registers.
//                Raises a stall request for the hazard unit while an
//                operation is being issued or is in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   pipeline clock, rising edge
//    rst        in   1   synchronous active-high reset
//    start      in   1   EX holds a valid MD instruction this cycle
//    md_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//                        6-7 no-op
//    src_a      in  32   rs operand
//    src_b      in  32   rt operand
//    busy       out  1   registered; operation in flight
//    stall_req  out  1   combinational: busy | (start & md_op <= 3)
//    hi         out 32   architectural HI
//    lo         out 32   architectural LO
// ============================================================================
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;

    localparam logic [2:0] c_OP_MTHI = 3'd4;
    localparam logic [2:0] c_OP_MTLO = 3'd5;

    localparam logic [3:0] c_MUL_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] c_DIV_CNT = 4'(DIV_LAT - 1);

    // Restoring-divider steps per cycle, rounded up so that DIV_LAT cycles
    // always cover all 32 quotient bits.
    localparam int c_STEPS = (32 + DIV_LAT - 1) / DIV_LAT;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] r_a;          // latched operands for the multiplier
    logic [31:0] r_b;
    logic        r_signed;     // MULT/DIV vs MULTU/DIVU

    logic [31:0] r_rem;        // partial remainder (magnitude)
    logic [31:0] r_quo;        // dividend shifting out / quotient shifting in
    logic [31:0] r_div_mag;    // divisor magnitude
    logic [5:0]  r_bits;       // quotient bits still to produce
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;         // divisor was zero: suppress the write

    // ------------------------------------------------------------------
    // Decoded controls (output-comb process fills these)
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_accept;
    logic w_mthi;
    logic w_mtlo;
    logic w_mul_done;
    logic w_div_done;
    logic w_md_req;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_prod;
    logic [31:0] w_rem;
    logic [31:0] w_quo;
    logic [5:0]  w_bits;
    logic [32:0] w_trial;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    // Operand magnitudes for the divider; unsigned ops pass straight through.
    assign w_mag_a = (~md_op[0] & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_mag_b = (~md_op[0] & src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign-extending to 64 bits makes one unsigned multiplier serve both
    // MULT and MULTU: the low 64 bits of the product are identical.
    assign w_prod = {{32{r_signed & r_a[31]}}, r_a} *
                    {{32{r_signed & r_b[31]}}, r_b};

    // c_STEPS restoring-division steps on the current partial state. The
    // bit counter stops the iteration once all 32 bits are produced, so
    // the extra capacity in the final cycles is harmless.
    always_comb begin
        w_rem   = r_rem;
        w_quo   = r_quo;
        w_bits  = r_bits;
        w_trial = 33'd0;
        for (int i = 0; i < c_STEPS; i++) begin
            if (w_bits != 6'd0) begin
                w_trial = {1'b0, w_rem[31:0]} << 1;
                w_trial[0] = w_quo[31];
                w_quo = {w_quo[30:0], 1'b0};
                if (w_trial >= {1'b0, r_div_mag}) begin
                    w_trial  = w_trial - {1'b0, r_div_mag};
                    w_quo[0] = 1'b1;
                end
                w_rem  = w_trial[31:0];
                w_bits = w_bits - 6'd1;
            end
        end
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_q_fin = r_neg_q ? (32'd0 - w_quo) : w_quo;
    assign w_r_fin = r_neg_r ? (32'd0 - w_rem) : w_rem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start && (md_op <= 3'd3)) begin
                    w_state_nxt = md_op[1] ? c_DIV : c_MUL;
                end
            end
            c_MUL, c_DIV: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_idle     = (r_state == c_IDLE);
        w_md_req   = start & (md_op <= 3'd3);
        w_accept   = w_idle & w_md_req;
        w_mthi     = w_idle & start & (md_op == c_OP_MTHI);
        w_mtlo     = w_idle & start & (md_op == c_OP_MTLO);
        w_mul_done = (r_state == c_MUL) & (r_cnt == 4'd0);
        w_div_done = (r_state == c_DIV) & (r_cnt == 4'd0);
        stall_req  = r_busy | w_md_req;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_signed  <= 1'b0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_div_mag <= 32'd0;
            r_bits    <= 6'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_IDLE);

            if (w_accept) begin
                r_cnt     <= md_op[1] ? c_DIV_CNT : c_MUL_CNT;
                r_a       <= src_a;
                r_b       <= src_b;
                r_signed  <= ~md_op[0];
                r_rem     <= 32'd0;
                r_quo     <= w_mag_a;
                r_div_mag <= w_mag_b;
                r_bits    <= 6'd32;
                r_neg_q   <= ~md_op[0] & (src_a[31] ^ src_b[31]);
                r_neg_r   <= ~md_op[0] & src_a[31];
                r_dz      <= (src_b == 32'd0);
            end else if (!w_idle && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (r_state == c_DIV) begin
                r_rem  <= w_rem;
                r_quo  <= w_quo;
                r_bits <= w_bits;
            end

            if (w_mthi) begin
                r_hi <= src_a;
            end
            if (w_mtlo) begin
                r_lo <= src_a;
            end

            if (w_mul_done) begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
            if (w_div_done && !r_dz) begin
                r_hi <= w_r_fin;
                r_lo <= w_q_fin;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Self-checking bench for md_unit. Directed and random
//                MD instructions are checked against a behavioural HI/LO
//                model computed with 64-bit integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: architectural effect of one accepted instruction.
    task automatic ref_exec(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2, 3'd3: begin
                if (b != 32'd0) begin
                    if (op == 3'd2) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one instruction and follow it to completion. With inject set,
    // a DIV is presented mid-busy and must be ignored.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        int lat;
        lat   = (op <= 3'd1) ? MULT_LAT : DIV_LAT;
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        check("stall_issue", 32'(stall_req), (op <= 3'd3) ? 32'd1 : 32'd0);
        tick();
        start = 1'b0;
        md_op = 3'd7;
        src_a = $urandom;
        src_b = $urandom;
        if (op <= 3'd3) begin
            for (int k = 0; k < lat; k++) begin
                check("busy_run",  32'(busy), 32'd1);
                check("stall_run", 32'(stall_req), 32'd1);
                check("hi_hold",   hi, m_hi);
                check("lo_hold",   lo, m_lo);
                if (inject && k == 2) begin
                    start = 1'b1;
                    md_op = 3'd2;
                    src_a = $urandom;
                    src_b = 32'd3;
                end else begin
                    start = 1'b0;
                    md_op = 3'd7;
                end
                tick();
            end
            start = 1'b0;
            md_op = 3'd7;
        end
        ref_exec(op, a, b);
        check("busy_done",  32'(busy), 32'd0);
        check("stall_done", 32'(stall_req), 32'd0);
        check("hi",         hi, m_hi);
        check("lo",         lo, m_lo);
    endtask

    task automatic expect_hl(input string tag, input logic [31:0] eh,
                             input logic [31:0] el);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        vectors     = 0;
        miscompares = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        rst   = 1'b1;
        start = 1'b0;
        md_op = 3'd7;
        src_a = 32'd0;
        src_b = 32'd0;
        tick();
        rst = 1'b0;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_hi",    hi, 32'd0);
        check("rst_lo",    lo, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);

        // Directed cases with hand-derived results.
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        expect_hl("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        expect_hl("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        expect_hl("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        expect_hl("divu", 32'd1, 32'd3);
        run_op(3'd4, 32'h1234, 32'd0, 1'b0);
        run_op(3'd5, 32'h5678, 32'd0, 1'b0);
        expect_hl("mtx", 32'h1234, 32'h5678);
        run_op(3'd2, 32'd99, 32'd0, 1'b0);
        expect_hl("div0", 32'h1234, 32'h5678);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        expect_hl("divovf", 32'd0, 32'h8000_0000);
        run_op(3'd0, 32'd3, 32'd4, 1'b1);
        expect_hl("inject", 32'd0, 32'd12);
        // Back-to-back: issued in the first non-busy cycle.
        run_op(3'd0, 32'hFFFF_FFFB, 32'd7, 1'b0);
        expect_hl("b2b", 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        run_op(3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);
        expect_hl("nop", 32'hFFFF_FFFF, 32'hFFFF_FFDD);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rb = 32'($urandom_range(1, 20));
            end
            run_op(rop, ra, rb, ($urandom_range(0, 4) == 0));
        end

        // Reset in the third busy cycle of a DIV aborts it.
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
        start = 1'b1;
        md_op = 3'd2;
        src_a = 32'd100;
        src_b = 32'd7;
        tick();
        start = 1'b0;
        md_op = 3'd7;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi",   hi, 32'd0);
        check("abort_lo",   lo, 32'd0);
        for (int k = 0; k < DIV_LAT + 2; k++) begin
            tick();
            check("late_busy", 32'(busy), 32'd0);
            check("late_hi",   hi, 32'd0);
            check("late_lo",   lo, 32'd0);
        end
        run_op(3'd3, 32'd1000, 32'd33, 1'b0);
        expect_hl("post_rst", 32'd10, 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
